// File: rtl/sipo_load_ctrl.sv
// Command/load sequencer between the UART receiver and the operand SIPOs.
// A command byte selects a vector load (A or B) or an operation; loads then
// stream exactly LENGTH bytes into the chosen SIPO, and operations raise a
// launch strobe and block new traffic until the result stage signals done.
module sipo_load_ctrl #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 1024,
  parameter int CNT_W  = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  input  logic             op_done,
  output logic [WIDTH-1:0] ser_out,
  output logic             write_a,
  output logic             write_b,
  output logic [2:0]       op_code,
  output logic             op_start,
  output logic             a_valid,
  output logic             b_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WAIT_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LENGTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ser_d;
  logic             wa_d, wb_d, ops_d, av_d, bv_d, busy_d, err_d;
  logic [2:0]       opc_d;
  logic [2:0]       cmd;

  assign cmd = rx_data[2:0];

  // Next-state and next-output decode; every output is registered below so
  // the strobes line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ser_d   = ser_out;
    wa_d    = 1'b0;
    wb_d    = 1'b0;
    ops_d   = 1'b0;
    opc_d   = op_code;
    av_d    = a_valid;
    bv_d    = b_valid;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          if (cmd == 3'd1) begin
            state_d = LOAD_A;
            cnt_d   = '0;
            av_d    = 1'b0;
          end else if (cmd == 3'd2) begin
            state_d = LOAD_B;
            cnt_d   = '0;
            bv_d    = 1'b0;
          end else if (cmd != 3'd0 && a_valid && b_valid) begin
            // op_start is high for exactly the one cycle spent in EXEC
            state_d = EXEC;
            opc_d   = cmd;
            ops_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (rx_ready) begin
          ser_d = rx_data;
          if (state_q == LOAD_A) wa_d = 1'b1;
          else                   wb_d = 1'b1;
          if (cnt_q == LAST) begin
            // last element: flag goes valid on the same edge as its write
            state_d = IDLE;
            if (state_q == LOAD_A) av_d = 1'b1;
            else                   bv_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EXEC: begin
        state_d = WAIT_DONE;
        err_d   = rx_ready;
      end
      WAIT_DONE: begin
        // bytes during an operation are dropped; op_done still completes it
        err_d = rx_ready;
        if (op_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ser_out  <= '0;
      write_a  <= 1'b0;
      write_b  <= 1'b0;
      op_code  <= 3'd0;
      op_start <= 1'b0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ser_out  <= ser_d;
      write_a  <= wa_d;
      write_b  <= wb_d;
      op_code  <= opc_d;
      op_start <= ops_d;
      a_valid  <= av_d;
      b_valid  <= bv_d;
      busy     <= busy_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// Bench for sipo_load_ctrl: a directed cycle table, two hand sequences, then
// random traffic checked against a transaction-level reference model.
module tb_sipo_load_ctrl;
  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] rx_data = '0;
  logic         rx_ready = 1'b0;
  logic         op_done = 1'b0;
  logic [W-1:0] ser_out;
  logic         write_a, write_b, op_start, a_valid, b_valid, busy, err;
  logic [2:0]   op_code;

  sipo_load_ctrl #(.WIDTH(W), .LENGTH(L)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .op_done(op_done), .ser_out(ser_out), .write_a(write_a),
    .write_b(write_b), .op_code(op_code), .op_start(op_start),
    .a_valid(a_valid), .b_valid(b_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // output bundle: {wa,wb,ops,av,bv,busy,err,opc[2:0],ser[7:0]}
  logic [17:0] act;
  assign act = {write_a, write_b, op_start, a_valid, b_valid, busy, err, op_code, ser_out};

  typedef struct {
    logic        rst, rdy;
    logic [7:0]  d;
    logic        done;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t v(input logic rst, rdy, input logic [7:0] d, input logic done,
                             input logic wa, wb, ops, av, bv, bsy, er,
                             input logic [2:0] opc, input logic [7:0] ser);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.d = d; r.done = done;
    r.exp = {wa, wb, ops, av, bv, bsy, er, opc, ser};
    return r;
  endfunction

  // one clock: inputs change at negedge, outputs sampled 1ns after posedge
  task automatic cyc(input logic r, rd, input logic [7:0] d, input logic dn);
    @(negedge clk);
    reset = r; rx_ready = rd; rx_data = d; op_done = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (wa wb ops av bv busy err opc ser)", name, act, exp);
    end
  endtask

  // reference model: tracks the pending transaction, not the controller's states
  int          m_tgt, m_left;
  bit          m_start, m_wait, m_av, m_bv;
  logic [2:0]  m_opc;
  logic [7:0]  m_ser;

  task automatic model_step(input logic r, rd, input logic [7:0] d, input logic dn,
                            output logic [17:0] exp);
    logic wa, wb, ops, er;
    wa = 0; wb = 0; ops = 0; er = 0;
    if (r) begin
      m_tgt = 0; m_left = 0; m_start = 0; m_wait = 0;
      m_av = 0; m_bv = 0; m_opc = 0; m_ser = 0;
    end else if (m_tgt != 0) begin
      if (rd) begin
        m_ser = d;
        if (m_tgt == 1) wa = 1; else wb = 1;
        m_left--;
        if (m_left == 0) begin
          if (m_tgt == 1) m_av = 1; else m_bv = 1;
          m_tgt = 0;
        end
      end
    end else if (m_start) begin
      m_start = 0; m_wait = 1; er = rd;
    end else if (m_wait) begin
      er = rd;
      if (dn) m_wait = 0;
    end else if (rd) begin
      case (d[2:0])
        3'd1: begin m_tgt = 1; m_left = L; m_av = 0; end
        3'd2: begin m_tgt = 2; m_left = L; m_bv = 0; end
        3'd0: er = 1;
        default: if (m_av && m_bv) begin m_start = 1; m_opc = d[2:0]; ops = 1; end
                 else er = 1;
      endcase
    end
    exp = {wa, wb, ops, m_av, m_bv, (m_tgt != 0) || m_start || m_wait, er, m_opc, m_ser};
  endtask

  initial begin
    logic [17:0] e;
    logic        r, rd, dn;
    logic [7:0]  d;

    //                rst rdy data  dn   wa wb ops av bv bsy er opc ser
    tbl[0]  = v(1, 0, 8'h00, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00);
    tbl[1]  = v(0, 1, 8'h01, 0,  0, 0, 0, 0, 0, 1, 0, 3'd0, 8'h00);
    tbl[2]  = v(0, 1, 8'h10, 0,  1, 0, 0, 0, 0, 1, 0, 3'd0, 8'h10);
    tbl[3]  = v(0, 1, 8'h11, 0,  1, 0, 0, 0, 0, 1, 0, 3'd0, 8'h11);
    tbl[4]  = v(0, 1, 8'h12, 0,  1, 0, 0, 0, 0, 1, 0, 3'd0, 8'h12);
    tbl[5]  = v(0, 1, 8'h13, 0,  1, 0, 0, 1, 0, 0, 0, 3'd0, 8'h13);
    tbl[6]  = v(0, 0, 8'h55, 0,  0, 0, 0, 1, 0, 0, 0, 3'd0, 8'h13);
    tbl[7]  = v(0, 1, 8'h05, 0,  0, 0, 0, 1, 0, 0, 1, 3'd0, 8'h13);
    tbl[8]  = v(0, 1, 8'h02, 0,  0, 0, 0, 1, 0, 1, 0, 3'd0, 8'h13);
    tbl[9]  = v(0, 1, 8'hA0, 0,  0, 1, 0, 1, 0, 1, 0, 3'd0, 8'hA0);
    tbl[10] = v(0, 1, 8'hA1, 0,  0, 1, 0, 1, 0, 1, 0, 3'd0, 8'hA1);
    tbl[11] = v(0, 1, 8'hA2, 0,  0, 1, 0, 1, 0, 1, 0, 3'd0, 8'hA2);
    tbl[12] = v(0, 1, 8'hA3, 0,  0, 1, 0, 1, 1, 0, 0, 3'd0, 8'hA3);
    tbl[13] = v(0, 1, 8'h05, 0,  0, 0, 1, 1, 1, 1, 0, 3'd5, 8'hA3);
    tbl[14] = v(0, 0, 8'h00, 0,  0, 0, 0, 1, 1, 1, 0, 3'd5, 8'hA3);
    tbl[15] = v(0, 1, 8'h02, 1,  0, 0, 0, 1, 1, 0, 1, 3'd5, 8'hA3);
    tbl[16] = v(0, 1, 8'h00, 0,  0, 0, 0, 1, 1, 0, 1, 3'd5, 8'hA3);
    tbl[17] = v(0, 1, 8'hF8, 0,  0, 0, 0, 1, 1, 0, 1, 3'd5, 8'hA3);
    tbl[18] = v(0, 1, 8'h09, 0,  0, 0, 0, 0, 1, 1, 0, 3'd5, 8'hA3);
    tbl[19] = v(0, 1, 8'h21, 0,  1, 0, 0, 0, 1, 1, 0, 3'd5, 8'h21);
    tbl[20] = v(0, 1, 8'h22, 0,  1, 0, 0, 0, 1, 1, 0, 3'd5, 8'h22);
    tbl[21] = v(1, 0, 8'h00, 0,  0, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00);
    tbl[22] = v(0, 1, 8'h01, 0,  0, 0, 0, 0, 0, 1, 0, 3'd0, 8'h00);
    tbl[23] = v(0, 1, 8'h30, 0,  1, 0, 0, 0, 0, 1, 0, 3'd0, 8'h30);
    tbl[24] = v(0, 1, 8'h31, 0,  1, 0, 0, 0, 0, 1, 0, 3'd0, 8'h31);
    tbl[25] = v(0, 1, 8'h32, 0,  1, 0, 0, 0, 0, 1, 0, 3'd0, 8'h32);
    tbl[26] = v(0, 1, 8'h33, 0,  1, 0, 0, 1, 0, 0, 0, 3'd0, 8'h33);
    tbl[27] = v(0, 0, 8'h00, 1,  0, 0, 0, 1, 0, 0, 0, 3'd0, 8'h33);

    for (int i = 0; i < 28; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].d, tbl[i].done);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // hand sequence: gapped load B, write_b only on cycles after a byte
    model_step(1, 0, 0, 0, e); cyc(1, 0, 8'h00, 0); chk("seq_rst", e);
    model_step(0, 1, 8'h02, 0, e); cyc(0, 1, 8'h02, 0); chk("seq_cmdb", e);
    for (int i = 0; i < L; i++) begin
      model_step(0, 1, 8'hC0 + 8'(i), 0, e); cyc(0, 1, 8'hC0 + 8'(i), 0); chk("seq_bbyte", e);
      model_step(0, 0, 8'hEE, 0, e); cyc(0, 0, 8'hEE, 0); chk("seq_bgap", e);
    end

    // hand sequence: op_done arriving during EXEC is ignored
    model_step(0, 1, 8'h01, 0, e); cyc(0, 1, 8'h01, 0); chk("seq_cmda", e);
    for (int i = 0; i < L; i++) begin
      model_step(0, 1, 8'h70 + 8'(i), 0, e); cyc(0, 1, 8'h70 + 8'(i), 0); chk("seq_abyte", e);
    end
    model_step(0, 1, 8'h07, 1, e); cyc(0, 1, 8'h07, 1); chk("seq_op7", e);
    model_step(0, 0, 8'h00, 1, e); cyc(0, 0, 8'h00, 1); chk("seq_exec_done", e);
    model_step(0, 0, 8'h00, 0, e); cyc(0, 0, 8'h00, 0); chk("seq_still_wait", e);
    model_step(0, 0, 8'h00, 1, e); cyc(0, 0, 8'h00, 1); chk("seq_done", e);

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 9) < 6);
      dn = ($urandom_range(0, 9) < 2);
      d  = 8'($urandom);
      if ($urandom_range(0, 2) != 0) d[2:0] = 3'($urandom_range(1, 5));
      model_step(r, rd, d, dn, e);
      cyc(r, rd, d, dn);
      chk("rand", e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sipo_load_ctrl.md
Name: sipo_load_ctrl

Overview:
Command/load sequencer between the UART receiver and the two vector SIPO shift registers (operand A, operand B) of the coprocessor.
- Decodes a command byte.
- Streams exactly LENGTH following bytes into the selected SIPO via its enable_write.
- Launches the combinational vector operation and holds off new traffic until the downstream result stage reports completion.

Parameters:
WIDTH, 8, byte/element width; equals SIPO WIDTH.
LENGTH, 1024, elements per vector; equals SIPO LENGTH; must be >= 2.
CNT_W, $clog2(LENGTH), element counter width.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous, active-high reset.
rx_data  input  WIDTH  received byte; valid only when rx_ready=1.
rx_ready  input  1  one-cycle strobe, new byte on rx_data.
op_done  input  1  one-cycle strobe from result/transmit stage: operation finished.
ser_out  output  WIDTH  data to ser_in of both SIPOs (shared bus).
write_a  output  1  enable_write of SIPO A.
write_b  output  1  enable_write of SIPO B.
op_code  output  3  opcode of the current/last operation.
op_start  output  1  one-cycle launch strobe.
a_valid  output  1  vector A fully loaded since last reset.
b_valid  output  1  vector B fully loaded since last reset.
busy  output  1  high in any state other than IDLE.
err  output  1  one-cycle error strobe.

Behaviour:
- Single clock clk. Reset synchronous, active-high. All outputs registered.
- Reset values:
  - State IDLE; count 0.
  - ser_out 0, write_a 0, write_b 0, op_code 0, op_start 0.
  - a_valid 0, b_valid 0, busy 0, err 0.
- Reset mid-load or mid-operation aborts immediately and clears the valid flags. SIPO contents are not cleared.
- Command byte = rx_data[2:0]:
  - 3'd1 = load A.
  - 3'd2 = load B.
  - 3'd3..3'd7 = operation with that opcode.
  - 3'd0 = invalid.
  - Bits [WIDTH-1:3] are ignored.
- FSM states: IDLE, LOAD_A, LOAD_B, EXEC, WAIT_DONE.
- IDLE, on rx_ready:
  - cmd 1 -> LOAD_A, count<=0, a_valid<=0.
  - cmd 2 -> LOAD_B, count<=0, b_valid<=0.
  - cmd 3..7 with a_valid&b_valid -> EXEC, op_code<=cmd.
  - cmd 3..7 with either flag clear -> err pulse, stay IDLE.
  - cmd 0 -> err pulse, stay IDLE.
- LOAD_A / LOAD_B, on rx_ready:
  - ser_out<=rx_data.
  - write_a (resp. write_b) high for exactly the next cycle; one-cycle latency from the rx_ready edge to write_x with matching ser_out.
  - count++.
  - The byte arriving at count==LENGTH-1 is the last: state -> IDLE, a_valid (resp. b_valid) <= 1 on the same edge.
  - Count never wraps inside a load.
  - The first byte loaded ends at SIPO index 0 after LENGTH shifts.
- Loading never drives both write_a and write_b high together.
- write_x is low whenever rx_ready was low on the previous cycle; ser_out holds its last value.
- EXEC: op_start=1 for exactly one cycle, then -> WAIT_DONE.
- WAIT_DONE: on op_done -> IDLE. op_code stays stable throughout EXEC/WAIT_DONE and after.
- rx_ready in EXEC or WAIT_DONE: byte dropped, err pulse. This includes a cycle where op_done also arrives; op_done still returns the FSM to IDLE.
- op_done outside WAIT_DONE is ignored.
- Back-to-back rx_ready on consecutive cycles is supported in every state.
- Valid flags persist across operations. Reloading A clears a_valid only until the reload completes.

Test Plan:
1. LENGTH=4; reset; send 0x01,0x10,0x11,0x12,0x13 -> write_a high 4 cycles (one per byte, 1 cycle after each rx_ready), ser_out 0x10..0x13; a_valid=1 after 0x13; busy=0; SIPO A par_out[0..3]=0x10..0x13.
2. From reset, send 0x05 -> err pulse, no op_start, state IDLE. Then load A and B, send 0x05 -> op_start single pulse, op_code=5, busy=1 until op_done strobe, then busy=0.
3. During WAIT_DONE, rx_ready with 0x02 in the same cycle as op_done -> err=1 for one cycle, FSM IDLE, write_b never asserted, b_valid unchanged.
4. Load B with rx_ready on 4 consecutive cycles (0xA0..0xA3) -> write_b high 4 consecutive cycles, ser_out tracks with 1-cycle lag, b_valid=1.
5. Assert reset after 2 of 4 bytes of load A -> next cycle busy=0, a_valid=0, write_a=0; a new 0x01 + 4 bytes completes normally.
6. Send 0x00 and 0xF8 (cmd bits 0) in IDLE -> err pulse each, no state change; send 0x09 -> decoded as load A.
